// File: rtl/axi_st_pkg.sv
// Shared definitions for the axi_st streaming interface and its FIFO.
//   axi_st_beat_t : one complete beat (payload plus every sideband), packed so
//                   it can be stored as a single RAM word.
//   beat_width()  : width of axi_st_beat_t, used to size the beat RAM.
package axi_st_pkg;

  localparam int AXI_ST_DATA_W = 8;
  localparam int AXI_ST_STRB_W = AXI_ST_DATA_W / 8;
  localparam int AXI_ST_ID_W   = 4;
  localparam int AXI_ST_DEST_W = 4;
  localparam int AXI_ST_USER_W = 4;

  typedef struct packed {
    logic [AXI_ST_DATA_W-1:0] tdata;
    logic [AXI_ST_STRB_W-1:0] tstrb;
    logic [AXI_ST_STRB_W-1:0] tkeep;
    logic                     tlast;
    logic [AXI_ST_ID_W-1:0]   tid;
    logic [AXI_ST_DEST_W-1:0] tdest;
    logic [AXI_ST_USER_W-1:0] tuser;
  } axi_st_beat_t;

  function automatic int beat_width();
    return $bits(axi_st_beat_t);
  endfunction

endpackage

// File: rtl/axi_st_if.sv
// axi_st streaming interface: one beat per tvalid && tready handshake.
//   master modport : drives tvalid and the beat fields, samples tready.
//   slave modport  : samples tvalid and the beat fields, drives tready.
interface axi_st;
  import axi_st_pkg::*;

  logic                     tvalid;
  logic                     tready;
  logic [AXI_ST_DATA_W-1:0] tdata;
  logic [AXI_ST_STRB_W-1:0] tstrb;
  logic [AXI_ST_STRB_W-1:0] tkeep;
  logic                     tlast;
  logic [AXI_ST_ID_W-1:0]   tid;
  logic [AXI_ST_DEST_W-1:0] tdest;
  logic [AXI_ST_USER_W-1:0] tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );

endinterface

// File: rtl/axi_st_fifo_ram.sv
// Simple dual-port beat storage: one synchronous write port, one
// asynchronous read port.
//   clk   : write clock
//   we    : write enable; waddr/wdata written on posedge clk
//   raddr : read address; rdata follows it combinationally
module axi_st_fifo_ram #(
  parameter  int DEPTH  = 16,
  parameter  int WIDTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; the FIFO pointers alone decide which
  // entries are valid, so clearing storage would only cost logic.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_st_fifo.sv
// First-word-fall-through FIFO for axi_st beats.
//   clk       : single clock, all logic on posedge
//   rst       : synchronous, active-high reset
//   s_axis    : upstream beats in (tready registered, never depends on m_axis.tready)
//   m_axis    : downstream beats out; head beat shown while tvalid
//   level     : beats stored, 0..DEPTH
//   pkt_count : stored beats carrying tlast, 0..DEPTH
module axi_st_fifo
  import axi_st_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  axi_st.slave            s_axis,
  axi_st.master           m_axis,
  output logic [ADDR_W:0] level,
  output logic [ADDR_W:0] pkt_count
);

  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  // Pointers carry one extra MSB: equal pointers mean empty, pointers that
  // differ only in the MSB mean full.
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            s_ready_q;
  logic            empty;
  logic            push;
  logic            pop;
  logic [ADDR_W:0] level_nxt;
  logic [ADDR_W:0] pkt_nxt;
  axi_st_beat_t    wr_beat;
  axi_st_beat_t    rd_beat;

  assign empty = (wr_ptr == rd_ptr);
  assign push  = s_axis.tvalid && s_ready_q;
  assign pop   = m_axis.tvalid && m_axis.tready;

  assign wr_beat = '{
    tdata: s_axis.tdata,
    tstrb: s_axis.tstrb,
    tkeep: s_axis.tkeep,
    tlast: s_axis.tlast,
    tid:   s_axis.tid,
    tdest: s_axis.tdest,
    tuser: s_axis.tuser
  };

  axi_st_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (beat_width())
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (wr_beat),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_beat)
  );

  // NOTE: every variable gets its default before the case, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    level_nxt = level;
    pkt_nxt   = pkt_count;
    case ({push, pop})
      2'b10:   level_nxt = level + CNT_ONE;
      2'b01:   level_nxt = level - CNT_ONE;
      default: ;
    endcase
    case ({push && s_axis.tlast, pop && rd_beat.tlast})
      2'b10:   pkt_nxt = pkt_count + CNT_ONE;
      2'b01:   pkt_nxt = pkt_count - CNT_ONE;
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pkt_count <= '0;
      s_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + CNT_ONE;
      if (pop)  rd_ptr <= rd_ptr + CNT_ONE;
      level     <= level_nxt;
      pkt_count <= pkt_nxt;
      // Registered from the next level so upstream ready never sees
      // downstream ready combinationally.
      s_ready_q <= (level_nxt != CNT_FULL);
    end
  end

  assign s_axis.tready = s_ready_q;

  assign m_axis.tvalid = !empty;
  assign m_axis.tdata  = rd_beat.tdata;
  assign m_axis.tstrb  = rd_beat.tstrb;
  assign m_axis.tkeep  = rd_beat.tkeep;
  assign m_axis.tlast  = rd_beat.tlast;
  assign m_axis.tid    = rd_beat.tid;
  assign m_axis.tdest  = rd_beat.tdest;
  assign m_axis.tuser  = rd_beat.tuser;

endmodule

// File: tb/tb_axi_st_fifo.sv
`timescale 1ns/1ps
module tb_axi_st_fifo;
  import axi_st_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  logic            clk = 1'b0;
  logic            rst;
  logic [ADDR_W:0] level;
  logic [ADDR_W:0] pkt_count;

  axi_st s_if ();
  axi_st m_if ();

  axi_st_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .level     (level),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: an ordered queue of stored beats plus a log of popped beats.
  axi_st_beat_t model_q[$];
  axi_st_beat_t popped[$];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic axi_st_beat_t mk(input logic [7:0] d, input logic l,
                                      input logic [3:0] id, input logic [3:0] dest,
                                      input logic [3:0] user);
    axi_st_beat_t b;
    b.tdata = d;
    b.tstrb = '1;
    b.tkeep = '1;
    b.tlast = l;
    b.tid   = id;
    b.tdest = dest;
    b.tuser = user;
    return b;
  endfunction

  function automatic axi_st_beat_t head_beat();
    axi_st_beat_t b;
    b.tdata = m_if.tdata;
    b.tstrb = m_if.tstrb;
    b.tkeep = m_if.tkeep;
    b.tlast = m_if.tlast;
    b.tid   = m_if.tid;
    b.tdest = m_if.tdest;
    b.tuser = m_if.tuser;
    return b;
  endfunction

  function automatic int model_pkts();
    int n = 0;
    foreach (model_q[i]) if (model_q[i].tlast) n++;
    return n;
  endfunction

  task automatic compare_model();
    check("m_level", int'(level), model_q.size());
    check("m_pkt_count", int'(pkt_count), model_pkts());
    check("m_tvalid", int'(m_if.tvalid), int'(model_q.size() != 0));
    check("s_tready", int'(s_if.tready), int'(model_q.size() < DEPTH));
    if (model_q.size() != 0) check("m_head", int'(head_beat()), int'(model_q[0]));
  endtask

  // One clock: drive inputs, advance one edge, update the model, compare.
  task automatic step(input logic r, input logic v, input axi_st_beat_t b, input logic mr);
    bit push;
    bit pop;
    rst         = r;
    s_if.tvalid = v;
    s_if.tdata  = b.tdata;
    s_if.tstrb  = b.tstrb;
    s_if.tkeep  = b.tkeep;
    s_if.tlast  = b.tlast;
    s_if.tid    = b.tid;
    s_if.tdest  = b.tdest;
    s_if.tuser  = b.tuser;
    m_if.tready = mr;
    push = !r && v && (model_q.size() < DEPTH);
    pop  = !r && mr && (model_q.size() != 0);
    @(posedge clk);
    #1;
    if (r) begin
      model_q.delete();
    end else begin
      if (pop) begin
        popped.push_back(model_q[0]);
        void'(model_q.pop_front());
      end
      if (push) model_q.push_back(b);
    end
    compare_model();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, mk(8'h00, 1'b0, 4'h0, 4'h0, 4'h0), 1'b0);
    step(1'b1, 1'b0, mk(8'h00, 1'b0, 4'h0, 4'h0, 4'h0), 1'b0);
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       mr;
    int         e_level;
    int         e_pkt;
    logic       e_mvalid;
    logic       e_sready;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    axi_st_beat_t b;
    int beat_idx;

    // Reset/idle, single-beat latency and stability, then a simultaneous push+pop.
    vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 8'h00};
    vecs[1] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1, 1, 1'b1, 1'b1, 8'hA5};
    for (int i = 2; i < 7; i++)
      vecs[i] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1, 1'b1, 1'b1, 8'hA5};
    vecs[7] = '{1'b1, 8'h3C, 1'b0, 1'b1, 1, 0, 1'b1, 1'b1, 8'h3C};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1, 8'h00};

    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    rst = 1'b1;
    do_reset();

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].v, mk(vecs[i].d, vecs[i].l, 4'h1, 4'h2, 4'h3), vecs[i].mr);
      check($sformatf("vec%0d_level", i), int'(level), vecs[i].e_level);
      check($sformatf("vec%0d_pkt", i), int'(pkt_count), vecs[i].e_pkt);
      check($sformatf("vec%0d_mvalid", i), int'(m_if.tvalid), int'(vecs[i].e_mvalid));
      check($sformatf("vec%0d_sready", i), int'(s_if.tready), int'(vecs[i].e_sready));
      if (vecs[i].e_mvalid)
        check($sformatf("vec%0d_data", i), int'(m_if.tdata), int'(vecs[i].e_data));
    end

    // Fill to capacity, hold a 17th beat upstream, then release one slot.
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b1, mk(8'(i), 1'b0, 4'h0, 4'h0, 4'h0), 1'b0);
    check("full_level", int'(level), DEPTH);
    check("full_sready", int'(s_if.tready), 0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, mk(8'd16, 1'b0, 4'h0, 4'h0, 4'h0), 1'b0);
    check("held_level", int'(level), DEPTH);
    check("held_head", int'(m_if.tdata), 0);
    step(1'b0, 1'b1, mk(8'd16, 1'b0, 4'h0, 4'h0, 4'h0), 1'b1);
    check("pop_full_sready", int'(s_if.tready), 1);
    check("pop_full_level", int'(level), DEPTH - 1);
    check("pop_full_popped", int'(popped[popped.size()-1].tdata), 0);
    step(1'b0, 1'b1, mk(8'd16, 1'b0, 4'h0, 4'h0, 4'h0), 1'b0);
    check("refill_level", int'(level), DEPTH);

    // Streaming: 40 beats back to back, crossing the pointer wrap twice.
    do_reset();
    popped.delete();
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, mk(8'(i), 1'b0, 4'h0, 4'h0, 4'h0), 1'b1);
      check("stream_level", int'(level), 1);
      check("stream_mvalid", int'(m_if.tvalid), 1);
      check("stream_head", int'(m_if.tdata), i);
    end
    step(1'b0, 1'b0, mk(8'h00, 1'b0, 4'h0, 4'h0, 4'h0), 1'b1);
    check("stream_drained", int'(level), 0);
    check("stream_count", popped.size(), 40);
    for (int i = 0; i < popped.size() && i < 40; i++)
      check("stream_order", int'(popped[i].tdata), i);

    // Random 3-beat packets with random downstream ready and sidebands.
    do_reset();
    beat_idx = 0;
    for (int c = 0; c < 400; c++) begin
      bit v;
      bit mr;
      v  = ($urandom_range(0, 3) != 0);
      mr = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      b  = mk(8'($urandom), (beat_idx % 3) == 2, 4'($urandom), 4'($urandom), 4'($urandom));
      b.tstrb = 1'($urandom);
      b.tkeep = 1'($urandom);
      if (v && model_q.size() < DEPTH) beat_idx++;
      step(1'b0, v, b, mr);
    end
    for (int c = 0; c < DEPTH + 2; c++)
      step(1'b0, 1'b0, mk(8'h00, 1'b0, 4'h0, 4'h0, 4'h0), 1'b1);
    check("rand_drained", int'(level), 0);

    // Reset in the middle of a packet with seven beats stored.
    do_reset();
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b1, mk(8'(8'h40 + i), (i == 2) || (i == 5), 4'h0, 4'h0, 4'h0), 1'b0);
    check("pre_rst_level", int'(level), 7);
    check("pre_rst_pkt", int'(pkt_count), 2);
    step(1'b1, 1'b1, mk(8'h47, 1'b0, 4'h0, 4'h0, 4'h0), 1'b0);
    check("rst_level", int'(level), 0);
    check("rst_pkt", int'(pkt_count), 0);
    check("rst_mvalid", int'(m_if.tvalid), 0);
    check("rst_sready", int'(s_if.tready), 1);
    popped.delete();
    step(1'b0, 1'b1, mk(8'h11, 1'b0, 4'h3, 4'h5, 4'h7), 1'b1);
    check("post_rst_no_bypass", popped.size(), 0);
    step(1'b0, 1'b1, mk(8'h22, 1'b1, 4'h3, 4'h5, 4'h8), 1'b1);
    step(1'b0, 1'b0, mk(8'h00, 1'b0, 4'h0, 4'h0, 4'h0), 1'b1);
    step(1'b0, 1'b0, mk(8'h00, 1'b0, 4'h0, 4'h0, 4'h0), 1'b1);
    check("post_rst_count", popped.size(), 2);
    if (popped.size() == 2) begin
      check("post_rst_beat0", int'(popped[0]), int'(mk(8'h11, 1'b0, 4'h3, 4'h5, 4'h7)));
      check("post_rst_beat1", int'(popped[1]), int'(mk(8'h22, 1'b1, 4'h3, 4'h5, 4'h8)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
